demux_dispatcher: RTL and testbench

//   Sequences the 1:N demux datapath as a registered stream dispatcher.

---
 rtl/demux_dispatcher.sv | 91 +++++++++
 tb/tb_demux_dispatcher.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/demux_dispatcher.sv
// rtl/demux_dispatcher.sv - 1:N registered stream dispatcher, round-robin or directed routing
module demux_dispatcher #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rr_mode,
  input  logic [N_OUT-1:0]  ch_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_dest,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  cur_sel,
  output logic [7:0]        drop_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_tgt;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] tgt;
  logic             rr_found;
  logic             tgt_ok;
  logic             accept;
  logic             load;
  logic             drop;

  // Cyclic search from rr_ptr; iterating downward leaves the nearest enabled channel.
  always_comb begin
    rr_found = 1'b0;
    rr_tgt   = rr_ptr;
    idx      = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      idx = rr_ptr + SEL_W'(i);
      if (ch_en[idx]) begin
        rr_found = 1'b1;
        rr_tgt   = idx;
      end
    end
  end

  assign tgt    = rr_mode ? rr_tgt : in_dest;
  assign tgt_ok = rr_mode ? rr_found : ch_en[in_dest];

  assign in_ready = (state == IDLE) ? 1'b1 : out_ready[cur_sel];
  assign accept   = in_valid & in_ready;
  assign load     = accept & tgt_ok;
  assign drop     = accept & ~tgt_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = HOLD;
      HOLD: if (out_ready[cur_sel] && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < N_OUT; i++) begin
      out_valid[i] = (state == HOLD) && (cur_sel == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      out_data <= '0;
      cur_sel  <= '0;
      rr_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_data <= in_data;
        cur_sel  <= tgt;
        if (rr_mode) rr_ptr <= tgt + SEL_W'(1);
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_dispatcher.sv
// tb/tb_demux_dispatcher.sv - directed vector bench for demux_dispatcher
module tb_demux_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       rr_mode;
  logic [3:0] ch_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] cur_sel;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_dispatcher #(.DATA_W(8), .N_OUT(4)) dut (
    .clk(clk), .reset(reset), .rr_mode(rr_mode), .ch_en(ch_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cur_sel(cur_sel), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic       rr;
    logic [3:0] chen;
    logic       v;
    logic [7:0] d;
    logic [1:0] dest;
    logic [3:0] ordy;
    logic       e_rdy;
    logic [3:0] e_ov;
    logic [7:0] e_d;
    logic [1:0] e_cs;
    logic [7:0] e_drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic rr, input logic [3:0] chen,
                              input logic v, input logic [7:0] d, input logic [1:0] dest,
                              input logic [3:0] ordy, input logic e_rdy, input logic [3:0] e_ov,
                              input logic [7:0] e_d, input logic [1:0] e_cs, input logic [7:0] e_drop);
    vec_t r;
    r = '{rst, rr, chen, v, d, dest, ordy, e_rdy, e_ov, e_d, e_cs, e_drop};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change after the falling edge; outputs are checked before the next rising edge.
  task automatic run_vec(input vec_t t, input string tag);
    @(negedge clk);
    reset     = t.rst;
    rr_mode   = t.rr;
    ch_en     = t.chen;
    in_valid  = t.v;
    in_data   = t.d;
    in_dest   = t.dest;
    out_ready = t.ordy;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(t.e_rdy));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(t.e_ov));
    chk({tag, " out_data"}, 32'(out_data), 32'(t.e_d));
    chk({tag, " cur_sel"}, 32'(cur_sel), 32'(t.e_cs));
    chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(t.e_drop));
  endtask

  initial begin
    reset = 1'b1; rr_mode = 1'b0; ch_en = 4'h0; in_valid = 1'b0;
    in_data = 8'h00; in_dest = 2'd0; out_ready = 4'h0;
    repeat (3) @(posedge clk);

    // round-robin over all channels, back to back; first row is the reset state
    tbl.push_back(mk(0,1,4'hF,1,8'h10,0,4'hF, 1,4'b0000,8'h00,0,0));
    tbl.push_back(mk(0,1,4'hF,1,8'h11,0,4'hF, 1,4'b0001,8'h10,0,0));
    tbl.push_back(mk(0,1,4'hF,1,8'h12,0,4'hF, 1,4'b0010,8'h11,1,0));
    tbl.push_back(mk(0,1,4'hF,1,8'h13,0,4'hF, 1,4'b0100,8'h12,2,0));
    tbl.push_back(mk(0,1,4'hF,1,8'h14,0,4'hF, 1,4'b1000,8'h13,3,0));
    tbl.push_back(mk(0,1,4'hF,1,8'h15,0,4'hF, 1,4'b0001,8'h14,0,0));
    tbl.push_back(mk(0,1,4'hF,1,8'h16,0,4'hF, 1,4'b0010,8'h15,1,0));
    tbl.push_back(mk(0,1,4'hF,1,8'h17,0,4'hF, 1,4'b0100,8'h16,2,0));
    tbl.push_back(mk(0,1,4'hF,0,8'h00,0,4'hF, 1,4'b1000,8'h17,3,0));
    tbl.push_back(mk(0,1,4'hF,0,8'h00,0,4'hF, 1,4'b0000,8'h17,3,0));
    // round-robin with mask 1010
    tbl.push_back(mk(0,1,4'hA,1,8'h20,0,4'hF, 1,4'b0000,8'h17,3,0));
    tbl.push_back(mk(0,1,4'hA,1,8'h21,0,4'hF, 1,4'b0010,8'h20,1,0));
    tbl.push_back(mk(0,1,4'hA,1,8'h22,0,4'hF, 1,4'b1000,8'h21,3,0));
    tbl.push_back(mk(0,1,4'hA,1,8'h23,0,4'hF, 1,4'b0010,8'h22,1,0));
    tbl.push_back(mk(0,1,4'hA,0,8'h00,0,4'hF, 1,4'b1000,8'h23,3,0));
    tbl.push_back(mk(0,1,4'hA,0,8'h00,0,4'hF, 1,4'b0000,8'h23,3,0));
    // directed to ch2 with ch2 stalled 5 cycles; other channels ready but ignored
    tbl.push_back(mk(0,0,4'hF,1,8'h30,2,4'hB, 1,4'b0000,8'h23,3,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,4'hF,1,8'h31,2,4'hB, 0,4'b0100,8'h30,2,0));
    tbl.push_back(mk(0,0,4'hF,1,8'h31,2,4'hF, 1,4'b0100,8'h30,2,0));
    tbl.push_back(mk(0,0,4'hF,0,8'h00,2,4'hF, 1,4'b0100,8'h31,2,0));
    tbl.push_back(mk(0,0,4'hF,0,8'h00,2,4'hF, 1,4'b0000,8'h31,2,0));

    foreach (tbl[k]) run_vec(tbl[k], $sformatf("vec%0d", k));

    // 300 directed beats to a disabled channel: all dropped, counter saturates
    for (int i = 0; i < 300; i++) begin
      run_vec(mk(0,0,4'h7,1,8'(i),3,4'hF, 1,4'b0000,8'h31,2,8'((i > 255) ? 255 : i)),
              $sformatf("drop%0d", i));
    end

    // held beat keeps ch1 after ch1 is disabled; next rr beat skips ch1
    run_vec(mk(0,1,4'hF,1,8'h4F,0,4'hF, 1,4'b0000,8'h31,2,8'hFF), "hold0");
    run_vec(mk(0,0,4'hF,1,8'h50,1,4'hF, 1,4'b0001,8'h4F,0,8'hFF), "hold1");
    run_vec(mk(0,0,4'hD,0,8'h00,1,4'hD, 0,4'b0010,8'h50,1,8'hFF), "hold2");
    run_vec(mk(0,0,4'hD,0,8'h00,1,4'hD, 0,4'b0010,8'h50,1,8'hFF), "hold3");
    run_vec(mk(0,1,4'hD,1,8'h51,0,4'hF, 1,4'b0010,8'h50,1,8'hFF), "hold4");
    run_vec(mk(0,1,4'hD,0,8'h00,0,4'hF, 1,4'b0100,8'h51,2,8'hFF), "hold5");
    run_vec(mk(0,1,4'hD,0,8'h00,0,4'hF, 1,4'b0000,8'h51,2,8'hFF), "hold6");

    // reset while a beat is held and stalled
    run_vec(mk(0,1,4'hF,1,8'h60,0,4'h0, 1,4'b0000,8'h51,2,8'hFF), "rst0");
    run_vec(mk(0,1,4'hF,0,8'h00,0,4'h0, 0,4'b1000,8'h60,3,8'hFF), "rst1");
    run_vec(mk(1,1,4'hF,0,8'h00,0,4'h0, 0,4'b1000,8'h60,3,8'hFF), "rst2");
    run_vec(mk(0,1,4'hF,1,8'h61,0,4'hF, 1,4'b0000,8'h00,0,8'h00), "rst3");
    run_vec(mk(0,1,4'hF,0,8'h00,0,4'hF, 1,4'b0001,8'h61,0,8'h00), "rst4");
    run_vec(mk(0,1,4'hF,0,8'h00,0,4'hF, 1,4'b0000,8'h61,0,8'h00), "rst5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
